// File: rtl/coeff_loader.sv
// Streams per-filter coefficients from a synchronous ROM into the control-register path.
// Optional running checksum of transferred coefficients: define COEFF_LOADER_CHKSUM_EN.
module coeff_loader #(
    parameter int unsigned NUM_FILTERS = 3,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned OP_W = 8,
    parameter int unsigned ROM_AW = 10,
    parameter int unsigned ROM_LAT = 1,
    parameter logic [NUM_FILTERS*IDX_W-1:0] COEFF_COUNTS = {8'd96, 8'd32, 8'd32},
    parameter logic [NUM_FILTERS*OP_W-1:0] OPCODES = {8'h46, 8'h45, 8'h44}
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            coeff_init,
    input  logic                            coeff_abort,
    input  logic [NUM_FILTERS-1:0]          filter_mask,
    output logic [ROM_AW-1:0]               rom_addr,
    input  logic [COEFF_W-1:0]              rom_data,
    output logic [COEFF_W+IDX_W+OP_W-1:0]   cr_coeff,
    output logic                            we_coeff,
    input  logic                            cr_ready,
    output logic                            coeff_busy,
    output logic                            coeff_done,
    output logic [COEFF_W-1:0]              coeff_chksum
);

    localparam int unsigned CMD_W = COEFF_W + IDX_W + OP_W;
    localparam int unsigned F_W   = $clog2(NUM_FILTERS + 1);
    localparam int unsigned F_N   = 2 ** F_W;
    localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, SEL, ADDR, WAIT, SEND, DONE} state_t;

    // ROM region start of filter f; masked filters still occupy their region.
    function automatic logic [ROM_AW-1:0] base_of(input int unsigned f);
        logic [ROM_AW-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < NUM_FILTERS; j++)
            if (j < f) s = s + ROM_AW'(COEFF_COUNTS[j*IDX_W +: IDX_W]);
        return s;
    endfunction

    logic [IDX_W-1:0]  cnt_tab  [F_N];
    logic [OP_W-1:0]   op_tab   [F_N];
    logic [ROM_AW-1:0] base_tab [F_N];

    // Tables padded to a power of two so any filter index value is in range.
    for (genvar g = 0; g < F_N; g++) begin : g_tab
        if (g < NUM_FILTERS) begin : g_used
            assign cnt_tab[g]  = COEFF_COUNTS[g*IDX_W +: IDX_W];
            assign op_tab[g]   = OPCODES[g*OP_W +: OP_W];
            assign base_tab[g] = base_of(g);
        end else begin : g_pad
            assign cnt_tab[g]  = '0;
            assign op_tab[g]   = '0;
            assign base_tab[g] = '0;
        end
    end

    state_t               state, state_n;
    logic [F_W-1:0]       f, f_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [NUM_FILTERS-1:0] mask_q, mask_n;
    logic [LAT_W-1:0]     lat_cnt, lat_n;
    logic [F_N-1:0]       mask_ext;
    logic                 xfer;
    logic                 last;

    logic [ROM_AW-1:0]    addr_n;
    logic [CMD_W-1:0]     cmd_n;
    logic                 busy_n, we_n, done_n;

    assign mask_ext = F_N'(mask_q);
    assign xfer     = (state == SEND) && cr_ready;
    assign last     = (idx == cnt_tab[f] - IDX_W'(1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            f          <= '0;
            idx        <= '0;
            mask_q     <= '0;
            lat_cnt    <= '0;
            rom_addr   <= '0;
            cr_coeff   <= '0;
            we_coeff   <= 1'b0;
            coeff_busy <= 1'b0;
            coeff_done <= 1'b0;
        end else begin
            state      <= state_n;
            f          <= f_n;
            idx        <= idx_n;
            mask_q     <= mask_n;
            lat_cnt    <= lat_n;
            rom_addr   <= addr_n;
            cr_coeff   <= cmd_n;
            we_coeff   <= we_n;
            coeff_busy <= busy_n;
            coeff_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        f_n     = f;
        idx_n   = idx;
        mask_n  = mask_q;
        lat_n   = lat_cnt;
        case (state)
            IDLE: if (coeff_init && !coeff_abort) begin
                state_n = SEL;
                mask_n  = filter_mask;
                f_n     = '0;
                idx_n   = '0;
            end
            SEL: begin
                if (f == F_W'(NUM_FILTERS))                 state_n = DONE;
                else if (mask_ext[f] && cnt_tab[f] != '0)   state_n = ADDR;
                else                                        f_n = f + F_W'(1);
            end
            ADDR: begin
                state_n = WAIT;
                lat_n   = '0;
            end
            WAIT: begin
                if (lat_cnt == LAT_W'(ROM_LAT - 1)) state_n = SEND;
                else                                lat_n = lat_cnt + LAT_W'(1);
            end
            SEND: if (xfer) begin
                if (last) begin
                    idx_n   = '0;
                    f_n     = f + F_W'(1);
                    state_n = SEL;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    state_n = ADDR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (coeff_abort && state != IDLE) state_n = IDLE;
    end

    // Registered outputs are derived from the state being entered.
    always_comb begin
        busy_n = (state_n != IDLE);
        we_n   = (state_n == SEND);
        done_n = (state_n == DONE);
        addr_n = rom_addr;
        cmd_n  = cr_coeff;
        if (state_n == ADDR) addr_n = base_tab[f_n] + ROM_AW'(idx_n);
        if (state == WAIT && state_n == SEND) cmd_n = {rom_data, idx, op_tab[f]};
    end

`ifdef COEFF_LOADER_CHKSUM_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                            coeff_chksum <= '0;
        else if (state == IDLE && state_n != IDLE) coeff_chksum <= '0;
        else if (xfer)                          coeff_chksum <= coeff_chksum + cr_coeff[CMD_W-1 -: COEFF_W];
    end
`else
    assign coeff_chksum = '0;
`endif

endmodule
